// File: rtl/control_pipe_pkg.sv
// Shared types and constants for the control pipeline: decoded control bundle,
// ALU op encodings and the per-stage register layouts with their bubble values.
package ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 3;

  // ALU op encodings from the decoder; this block only carries them to EX.
  localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB    = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT  = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'd4;

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic               alu_src;
    logic               branch;
    logic               mem_read;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic                  valid;
    ctrl_bundle_t          ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic [REG_ADDR_W-1:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } wb_stage_t;

  localparam ex_stage_t  EX_BUBBLE  = '{valid: 1'b0, ctrl: CTRL_BUBBLE, rd: '0};
  localparam mem_stage_t MEM_BUBBLE = '0;
  localparam wb_stage_t  WB_BUBBLE  = '0;

  function automatic logic reg_matches(input logic [REG_ADDR_W-1:0] a,
                                       input logic [REG_ADDR_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Decode-side inputs and per-stage control outputs of control_pipe.
// master: the decode/datapath side; slave: the control pipe itself.
interface control_pipe_if;
  import ctrl_pkg::*;

  logic                  Valid_in;
  logic                  RegWrite_in;
  logic                  MemWrite_in;
  logic                  ALUSrc_in;
  logic                  Branch_in;
  logic                  MemRead_in;
  logic [ALUOP_W-1:0]    ALUOp_in;
  logic [REG_ADDR_W-1:0] Rd_in;
  logic [REG_ADDR_W-1:0] Rs1_in;
  logic [REG_ADDR_W-1:0] Rs2_in;
  logic                  Flush_in;
  logic                  Stall_out;

  logic                  ExValid_out;
  logic                  ExRegWrite_out;
  logic                  ExMemWrite_out;
  logic                  ExALUSrc_out;
  logic                  ExBranch_out;
  logic                  ExMemRead_out;
  logic [ALUOP_W-1:0]    ExALUOp_out;
  logic [REG_ADDR_W-1:0] ExRd_out;

  logic                  MemValid_out;
  logic                  MemRegWrite_out;
  logic                  MemMemWrite_out;
  logic                  MemMemRead_out;
  logic                  MemBranch_out;
  logic [REG_ADDR_W-1:0] MemRd_out;

  logic                  WbValid_out;
  logic                  WbRegWrite_out;
  logic                  WbMemToReg_out;
  logic [REG_ADDR_W-1:0] WbRd_out;

  modport master (
    output Valid_in, RegWrite_in, MemWrite_in, ALUSrc_in, Branch_in, MemRead_in,
           ALUOp_in, Rd_in, Rs1_in, Rs2_in, Flush_in,
    input  Stall_out,
           ExValid_out, ExRegWrite_out, ExMemWrite_out, ExALUSrc_out, ExBranch_out,
           ExMemRead_out, ExALUOp_out, ExRd_out,
           MemValid_out, MemRegWrite_out, MemMemWrite_out, MemMemRead_out,
           MemBranch_out, MemRd_out,
           WbValid_out, WbRegWrite_out, WbMemToReg_out, WbRd_out
  );

  modport slave (
    input  Valid_in, RegWrite_in, MemWrite_in, ALUSrc_in, Branch_in, MemRead_in,
           ALUOp_in, Rd_in, Rs1_in, Rs2_in, Flush_in,
    output Stall_out,
           ExValid_out, ExRegWrite_out, ExMemWrite_out, ExALUSrc_out, ExBranch_out,
           ExMemRead_out, ExALUOp_out, ExRd_out,
           MemValid_out, MemRegWrite_out, MemMemWrite_out, MemMemRead_out,
           MemBranch_out, MemRd_out,
           WbValid_out, WbRegWrite_out, WbMemToReg_out, WbRd_out
  );

endinterface

// File: rtl/control_pipe_stage_reg.sv
// ctrl_stage_reg: one pipeline register that resets to, or can be forced to,
// its bubble value; otherwise it loads d every cycle.
module ctrl_stage_reg #(
  parameter int               WIDTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert_bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || insert_bubble) begin
      q <= BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: carries decoded control through EX/MEM/WB and inserts a bubble
// on load-use hazards or flushes. Define CTRL_PIPE_PERF_EN to add perf counters.
module control_pipe
  import ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  control_pipe_if.slave bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0] RetiredCount_out,
  output logic [31:0] BubbleCount_out
`endif
);

  ex_stage_t  ex_d, ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d, wb_q;
  logic       hazard;
  logic       ex_insert_bubble;

  // A load in EX whose rd feeds the ID instruction must wait one cycle; a
  // flush kills the ID instruction anyway, so it suppresses the stall.
  assign hazard = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) &&
                  bus.Valid_in && !bus.Flush_in &&
                  (reg_matches(ex_q.rd, bus.Rs1_in) || reg_matches(ex_q.rd, bus.Rs2_in));

  assign ex_insert_bubble = !bus.Valid_in || bus.Flush_in || hazard;
  assign bus.Stall_out    = hazard;

  always_comb begin
    ex_d                = EX_BUBBLE;
    ex_d.valid          = 1'b1;
    ex_d.ctrl.reg_write = bus.RegWrite_in;
    ex_d.ctrl.mem_write = bus.MemWrite_in;
    ex_d.ctrl.alu_src   = bus.ALUSrc_in;
    ex_d.ctrl.branch    = bus.Branch_in;
    ex_d.ctrl.mem_read  = bus.MemRead_in;
    ex_d.ctrl.alu_op    = bus.ALUOp_in;
    ex_d.rd             = bus.Rd_in;
  end

  // MEM no longer needs the ALU controls; WB only needs the write-back path.
  always_comb begin
    mem_d           = MEM_BUBBLE;
    mem_d.valid     = ex_q.valid;
    mem_d.reg_write = ex_q.ctrl.reg_write;
    mem_d.mem_write = ex_q.ctrl.mem_write;
    mem_d.mem_read  = ex_q.ctrl.mem_read;
    mem_d.branch    = ex_q.ctrl.branch;
    mem_d.rd        = ex_q.rd;

    wb_d            = WB_BUBBLE;
    wb_d.valid      = mem_q.valid;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_read;
    wb_d.rd         = mem_q.rd;
  end

  ctrl_stage_reg #(
    .WIDTH  ($bits(ex_stage_t)),
    .BUBBLE (EX_BUBBLE)
  ) u_ex_reg (
    .clk           (clk_i),
    .rst           (rst_i),
    .insert_bubble (ex_insert_bubble),
    .d             (ex_d),
    .q             (ex_q)
  );

  ctrl_stage_reg #(
    .WIDTH  ($bits(mem_stage_t)),
    .BUBBLE (MEM_BUBBLE)
  ) u_mem_reg (
    .clk           (clk_i),
    .rst           (rst_i),
    .insert_bubble (1'b0),
    .d             (mem_d),
    .q             (mem_q)
  );

  ctrl_stage_reg #(
    .WIDTH  ($bits(wb_stage_t)),
    .BUBBLE (WB_BUBBLE)
  ) u_wb_reg (
    .clk           (clk_i),
    .rst           (rst_i),
    .insert_bubble (1'b0),
    .d             (wb_d),
    .q             (wb_q)
  );

  assign bus.ExValid_out    = ex_q.valid;
  assign bus.ExRegWrite_out = ex_q.ctrl.reg_write;
  assign bus.ExMemWrite_out = ex_q.ctrl.mem_write;
  assign bus.ExALUSrc_out   = ex_q.ctrl.alu_src;
  assign bus.ExBranch_out   = ex_q.ctrl.branch;
  assign bus.ExMemRead_out  = ex_q.ctrl.mem_read;
  assign bus.ExALUOp_out    = ex_q.ctrl.alu_op;
  assign bus.ExRd_out       = ex_q.rd;

  assign bus.MemValid_out    = mem_q.valid;
  assign bus.MemRegWrite_out = mem_q.reg_write;
  assign bus.MemMemWrite_out = mem_q.mem_write;
  assign bus.MemMemRead_out  = mem_q.mem_read;
  assign bus.MemBranch_out   = mem_q.branch;
  assign bus.MemRd_out       = mem_q.rd;

  // The WB register keeps the raw write enable; x0 is masked only here.
  assign bus.WbValid_out    = wb_q.valid;
  assign bus.WbRegWrite_out = wb_q.reg_write && (wb_q.rd != '0);
  assign bus.WbMemToReg_out = wb_q.mem_to_reg;
  assign bus.WbRd_out       = wb_q.rd;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] bubble_cnt;

  // Bubbles count only real ID instructions lost to a stall or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (wb_q.valid) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (bus.Valid_in && (bus.Flush_in || hazard)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign RetiredCount_out = retired_cnt;
  assign BubbleCount_out  = bubble_cnt;
`endif

endmodule
